// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: requests words at the current PC, presents each
// fetched word to the decoder over valid/ready, and steers the external PC
// register through one-cycle increment and load strobes.
module fetch_sequencer #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] pc_value,
    output logic                  pc_inc,
    output logic                  pc_load,
    output logic [ADDR_WIDTH-1:0] pc_load_value,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    input  logic                  halt,
    output logic                  busy,
    output logic                  fetch_error
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    // Value the counter holds during the last permitted wait cycle.
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_ADVANCE,
        S_REDIRECT,
        S_HALTED,
        S_ERROR
    } state_t;

    state_t                state_q, state_d;
    logic                  redirect_pend_q, redirect_pend_d;
    logic [ADDR_WIDTH-1:0] redirect_target_q, redirect_target_d;
    logic [CNT_W-1:0]      timeout_cnt_q, timeout_cnt_d;
    logic [DATA_WIDTH-1:0] instr_data_q, instr_data_d;
    logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;

    // State register and datapath flops; reset wins over every state.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q           <= S_IDLE;
            redirect_pend_q   <= 1'b0;
            redirect_target_q <= '0;
            timeout_cnt_q     <= '0;
            instr_data_q      <= '0;
            instr_pc_q        <= '0;
        end else begin
            state_q           <= state_d;
            redirect_pend_q   <= redirect_pend_d;
            redirect_target_q <= redirect_target_d;
            timeout_cnt_q     <= timeout_cnt_d;
            instr_data_q      <= instr_data_d;
            instr_pc_q        <= instr_pc_d;
        end
    end

    // Next-state logic and Moore-style strobes decoded from the current state.
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_d           = state_q;
        redirect_pend_d   = redirect_pend_q;
        redirect_target_d = redirect_target_q;
        timeout_cnt_d     = timeout_cnt_q;
        instr_data_d      = instr_data_q;
        instr_pc_d        = instr_pc_q;
        pc_inc            = 1'b0;
        pc_load           = 1'b0;
        pc_load_value     = '0;
        imem_req          = 1'b0;
        imem_addr         = '0;
        instr_valid       = 1'b0;
        busy              = 1'b0;
        fetch_error       = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = halt ? S_HALTED : S_REQ;
            end
            S_REQ: begin
                imem_req  = 1'b1;
                imem_addr = pc_value;
                busy      = 1'b1;
                if (redirect_valid) begin
                    redirect_target_d = redirect_target;
                end
                if (imem_ack) begin
                    instr_data_d  = imem_rdata;
                    instr_pc_d    = pc_value;
                    timeout_cnt_d = '0;
                    // A redirect seen during the request makes this word stale.
                    state_d = (redirect_pend_q || redirect_valid) ? S_REDIRECT : S_HOLD;
                end else begin
                    if (redirect_valid) begin
                        redirect_pend_d = 1'b1;
                    end
                    if (TIMEOUT_CYCLES != 0) begin
                        if (timeout_cnt_q == CNT_LAST) begin
                            state_d = S_ERROR;
                        end else begin
                            timeout_cnt_d = timeout_cnt_q + 1'b1;
                        end
                    end
                end
            end
            S_HOLD: begin
                instr_valid = 1'b1;
                busy        = 1'b1;
                if (redirect_valid) begin
                    redirect_target_d = redirect_target;
                    state_d           = S_REDIRECT;
                end else if (instr_ready) begin
                    state_d = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                pc_inc = 1'b1;
                busy   = 1'b1;
                if (redirect_valid) begin
                    redirect_target_d = redirect_target;
                    state_d           = S_REDIRECT;
                end else if (halt) begin
                    state_d = S_HALTED;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_REDIRECT: begin
                pc_load         = 1'b1;
                pc_load_value   = redirect_target_q;
                busy            = 1'b1;
                redirect_pend_d = 1'b0;
                state_d         = halt ? S_HALTED : S_REQ;
            end
            S_HALTED: begin
                if (redirect_valid) begin
                    redirect_target_d = redirect_target;
                    state_d           = S_REDIRECT;
                end else if (!halt) begin
                    state_d = S_REQ;
                end
            end
            S_ERROR: begin
                fetch_error = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign instr_data = instr_data_q;
    assign instr_pc   = instr_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a word-indexed PC register model and a
// memory returning 0x100+addr after a programmable number of wait cycles.
module tb_fetch_sequencer;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] pc_value;
    logic          pc_inc;
    logic          pc_load;
    logic [AW-1:0] pc_load_value;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [DW-1:0] imem_rdata;
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] instr_data;
    logic [AW-1:0] instr_pc;
    logic          redirect_valid;
    logic [AW-1:0] redirect_target;
    logic          halt;
    logic          busy;
    logic          fetch_error;

    int tests_run    = 0;
    int tests_failed = 0;

    logic        ack_en;
    int unsigned ack_delay;
    int unsigned wait_cnt;

    fetch_sequencer #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_value       (pc_value),
        .pc_inc         (pc_inc),
        .pc_load        (pc_load),
        .pc_load_value  (pc_load_value),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .halt           (halt),
        .busy           (busy),
        .fetch_error    (fetch_error)
    );

    always #5 clk = ~clk;

    // Memory: ack once the request has waited ack_delay cycles.
    assign imem_ack   = imem_req && ack_en && (wait_cnt >= ack_delay);
    assign imem_rdata = 32'h100 + imem_addr;

    always @(posedge clk) begin
        if (reset || !imem_req || imem_ack) wait_cnt <= 0;
        else                                wait_cnt <= wait_cnt + 1;
    end

    // PC register: load has priority over increment.
    always @(posedge clk) begin
        if (reset)        pc_value <= '0;
        else if (pc_load) pc_value <= pc_load_value;
        else if (pc_inc)  pc_value <= pc_value + 1;
    end

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in IDLE with reset just released.
    task automatic apply_reset();
        reset          = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = '0;
        halt           = 1'b0;
        ack_en         = 1'b1;
        ack_delay      = 0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        instr_ready = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        halt = 1'b0; ack_en = 1'b1; ack_delay = 0;
        step();
        step();
        tests_run++;
        if ({pc_inc, pc_load, imem_req, instr_valid, busy, fetch_error} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_strobes got=%b want=000000",
                     {pc_inc, pc_load, imem_req, instr_valid, busy, fetch_error});
        end
        tests_run++;
        if ({pc_load_value, imem_addr, instr_data, instr_pc} !== '0) begin
            tests_failed++;
            $display("FAIL reset_buses got=%h/%h/%h/%h want=0",
                     pc_load_value, imem_addr, instr_data, instr_pc);
        end
    endtask

    // Zero-wait memory, decoder always ready.
    task automatic test_stream();
        int incs = 0;
        int loads = 0;
        apply_reset();
        instr_ready = 1'b1;
        // First cycle with reset low is IDLE: no request yet.
        tests_run++;
        if (imem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL first_req_early got=%b want=0", imem_req);
        end
        step();
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL first_req got=%b addr=%h want=1 addr=0", imem_req, imem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (imem_req !== 1'b1 || imem_addr !== AW'(i)) begin
                tests_failed++;
                $display("FAIL stream_req%0d got=%b addr=%h want=1 addr=%h", i, imem_req, imem_addr, i);
            end
            incs += int'(pc_inc); loads += int'(pc_load);
            step();
            tests_run++;
            if (instr_valid !== 1'b1 || instr_data !== DW'(32'h100 + i) || instr_pc !== AW'(i)) begin
                tests_failed++;
                $display("FAIL stream_data%0d got=%b %h@%h want=1 %h@%h",
                         i, instr_valid, instr_data, instr_pc, 32'h100 + i, i);
            end
            incs += int'(pc_inc); loads += int'(pc_load);
            step();
            tests_run++;
            if (pc_inc !== 1'b1) begin
                tests_failed++;
                $display("FAIL stream_inc%0d got=%b want=1", i, pc_inc);
            end
            incs += int'(pc_inc); loads += int'(pc_load);
            step();
        end
        tests_run++;
        if (incs != 3 || loads != 0) begin
            tests_failed++;
            $display("FAIL stream_strobes got inc=%0d load=%0d want inc=3 load=0", incs, loads);
        end
    endtask

    // Four wait states on memory, then five stalled cycles in HOLD.
    task automatic test_stall();
        int incs = 0;
        apply_reset();
        ack_delay = 4;
        step();
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall_req%0d got req=%b addr=%h valid=%b want 1 0 0",
                         i, imem_req, imem_addr, instr_valid);
            end
            step();
        end
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (instr_valid !== 1'b1 || instr_data !== 32'h100 || imem_req !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall_hold%0d got valid=%b data=%h req=%b want 1 100 0",
                         i, instr_valid, instr_data, imem_req);
            end
            incs += int'(pc_inc);
            step();
        end
        instr_ready = 1'b1;
        ack_delay = 0;
        incs += int'(pc_inc);
        step();
        incs += int'(pc_inc);
        instr_ready = 1'b0;
        step();
        incs += int'(pc_inc);
        tests_run++;
        if (incs != 1 || imem_req !== 1'b1 || imem_addr !== 32'h1) begin
            tests_failed++;
            $display("FAIL stall_advance got inc=%0d req=%b addr=%h want 1 1 1", incs, imem_req, imem_addr);
        end
    endtask

    // Redirect to 0x40 in the second wait cycle of a slow request.
    task automatic test_redirect_in_req();
        apply_reset();
        ack_delay = 4;
        instr_ready = 1'b1;
        step();
        step();
        redirect_valid = 1'b1;
        redirect_target = 32'h40;
        step();
        redirect_valid = 1'b0;
        redirect_target = '0;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0 || pc_load !== 1'b0) begin
                tests_failed++;
                $display("FAIL redir_req%0d got req=%b addr=%h valid=%b load=%b want 1 0 0 0",
                         i, imem_req, imem_addr, instr_valid, pc_load);
            end
            step();
        end
        tests_run++;
        if (pc_load !== 1'b1 || pc_load_value !== 32'h40 || instr_valid !== 1'b0 || pc_inc !== 1'b0) begin
            tests_failed++;
            $display("FAIL redir_load got load=%b val=%h valid=%b inc=%b want 1 40 0 0",
                     pc_load, pc_load_value, instr_valid, pc_inc);
        end
        step();
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            tests_failed++;
            $display("FAIL redir_next got req=%b addr=%h want 1 40", imem_req, imem_addr);
        end
    endtask

    // Redirect to 0x80 coinciding with a valid&ready transfer in HOLD.
    task automatic test_redirect_in_hold();
        apply_reset();
        step();
        step();
        instr_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 32'h80;
        tests_run++;
        if (instr_valid !== 1'b1 || instr_data !== 32'h100) begin
            tests_failed++;
            $display("FAIL hold_redir_xfer got valid=%b data=%h want 1 100", instr_valid, instr_data);
        end
        step();
        redirect_valid = 1'b0;
        redirect_target = '0;
        tests_run++;
        if (pc_inc !== 1'b0 || pc_load !== 1'b1 || pc_load_value !== 32'h80) begin
            tests_failed++;
            $display("FAIL hold_redir_load got inc=%b load=%b val=%h want 0 1 80", pc_inc, pc_load, pc_load_value);
        end
        step();
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h80 || pc_inc !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_redir_next got req=%b addr=%h inc=%b want 1 80 0", imem_req, imem_addr, pc_inc);
        end
        step();
        tests_run++;
        if (instr_valid !== 1'b1 || instr_data !== 32'h180 || instr_pc !== 32'h80) begin
            tests_failed++;
            $display("FAIL hold_redir_data got valid=%b %h@%h want 1 180@80", instr_valid, instr_data, instr_pc);
        end
    endtask

    // Halt raised while an instruction waits in HOLD.
    task automatic test_halt();
        apply_reset();
        step();
        step();
        halt = 1'b1;
        step();
        tests_run++;
        if (instr_valid !== 1'b1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL halt_hold got valid=%b busy=%b want 1 1", instr_valid, busy);
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        tests_run++;
        if (pc_inc !== 1'b1) begin
            tests_failed++;
            $display("FAIL halt_advance got inc=%b want 1", pc_inc);
        end
        step();
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if (imem_req !== 1'b0 || busy !== 1'b0 || pc_inc !== 1'b0) begin
                tests_failed++;
                $display("FAIL halt_idle%0d got req=%b busy=%b inc=%b want 0 0 0", i, imem_req, busy, pc_inc);
            end
            step();
        end
        halt = 1'b0;
        step();
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h1) begin
            tests_failed++;
            $display("FAIL halt_resume got req=%b addr=%h want 1 1", imem_req, imem_addr);
        end
    endtask

    // Memory never acks: the eighth unanswered REQ cycle traps.
    task automatic test_timeout();
        apply_reset();
        ack_en = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (imem_req !== 1'b1 || fetch_error !== 1'b0) begin
                tests_failed++;
                $display("FAIL timeout_req%0d got req=%b err=%b want 1 0", i, imem_req, fetch_error);
            end
            step();
        end
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (fetch_error !== 1'b1 || imem_req !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL timeout_err%0d got err=%b req=%b busy=%b want 1 0 0", i, fetch_error, imem_req, busy);
            end
            step();
        end
        apply_reset();
        tests_run++;
        if (fetch_error !== 1'b0 || imem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_clear got err=%b req=%b want 0 0", fetch_error, imem_req);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_in_req();
        test_redirect_in_hold();
        test_halt();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
